// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter:
//   - arb_state_t : arbiter FSM state encodings
//   - ZeroWord, WriteDisable and the byte-enable constants
//   - is_store()  : true when a byte-enable vector writes at least one byte
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT_IF  = 2'd1,
    ARB_GNT_MEM = 2'd2
  } arb_state_t;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [3:0]  WriteDisable = 4'b0000;
  localparam logic [3:0]  ByteEn0      = 4'b0001;
  localparam logic [3:0]  ByteEn1      = 4'b0010;
  localparam logic [3:0]  ByteEn2      = 4'b0100;
  localparam logic [3:0]  ByteEn3      = 4'b1000;
  localparam logic [3:0]  ByteEnHalfLo = 4'b0011;
  localparam logic [3:0]  ByteEnHalfHi = 4'b1100;
  localparam logic [3:0]  ByteEnAll    = 4'b1111;

  function automatic logic is_store(input logic [3:0] we);
    return we != WriteDisable;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// -----------------------------------------------------------------------------
// bus_timeout_cnt
// Busy-cycle counter for one bus grant. Counts while en is high, returns to
// zero on clr, and raises tc while the count equals TIMEOUT-1 (i.e. during the
// TIMEOUT-th busy cycle). Intended for TIMEOUT >= 1; the parent ties tc low
// instead of instantiating this when the timeout is disabled.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to 0 (priority over en)
//   en       : advance count by one
//   tc       : terminal-count flag (combinational from the count)
// -----------------------------------------------------------------------------
module bus_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-ported RAM bus between the instruction fetch port
// (read only) and the mem-stage port (loads and byte-enabled stores).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   if_req/if_addr                 : fetch request, held until if_ack
//   if_ack/if_rdata                : fetch completion + data (combinational)
//   mem_req/mem_addr/mem_we/wdata  : load/store request, held until mem_ack
//   mem_ack/mem_rdata              : load/store completion + data (comb.)
//   stallreq_if/stallreq_mem       : pipeline stall requests (combinational)
//   ram_ce_o/addr_o/we_o/wdata_o   : registered RAM command
//   ram_rdata_i/ram_ready_i        : RAM read data, access-complete strobe
//   bus_err_o                      : registered one-cycle timeout-abort pulse
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_we,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              ram_ce_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ready_i,
  output logic              bus_err_o
);

  arb_state_t        state_reg, state_next;
  logic              ram_ce_reg, ram_ce_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [3:0]        ram_we_reg, ram_we_next;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
  logic              bus_err_reg, bus_err_next;

  logic busy;
  logic tc;
  logic finish;

  assign busy   = (state_reg != ARB_IDLE);
  // A grant ends either on RAM ready or on timeout; ready wins if both.
  assign finish = busy && (ram_ready_i || tc);

  generate
    if (TIMEOUT > 0) begin : g_timeout
      bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (finish || !busy),
        .en  (busy),
        .tc  (tc)
      );
    end else begin : g_no_timeout
      assign tc = 1'b0;
    end
  endgenerate

  // State and registered bus command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB_IDLE;
      ram_ce_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_we_reg    <= WriteDisable;
      ram_wdata_reg <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ram_ce_reg    <= ram_ce_next;
      ram_addr_reg  <= ram_addr_next;
      ram_we_reg    <= ram_we_next;
      ram_wdata_reg <= ram_wdata_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  // Next state. On completion the other requester is granted directly; the
  // just-served one is never re-granted, so continuous requests alternate.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (mem_req)     state_next = ARB_GNT_MEM;
        else if (if_req) state_next = ARB_GNT_IF;
      end
      ARB_GNT_IF: begin
        if (finish) state_next = mem_req ? ARB_GNT_MEM : ARB_IDLE;
      end
      ARB_GNT_MEM: begin
        if (finish) state_next = if_req ? ARB_GNT_IF : ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Outputs: acks, read data, and the next RAM command
  always_comb begin
    ram_ce_next    = ram_ce_reg;
    ram_addr_next  = ram_addr_reg;
    ram_we_next    = ram_we_reg;
    ram_wdata_next = ram_wdata_reg;
    bus_err_next   = finish && !ram_ready_i;

    // A requester that dropped its req early loses its ack; the grant still ends.
    if_ack  = (state_reg == ARB_GNT_IF)  && finish && if_req;
    mem_ack = (state_reg == ARB_GNT_MEM) && finish && mem_req;

    if_rdata  = (if_ack && ram_ready_i) ? ram_rdata_i : DATA_W'(ZeroWord);
    mem_rdata = (mem_ack && ram_ready_i && !is_store(ram_we_reg))
                ? ram_rdata_i : DATA_W'(ZeroWord);

    // Self-transitions never happen on a completion edge, so a state change
    // marks exactly the edges where the command must be reloaded or dropped.
    if (state_next != state_reg) begin
      case (state_next)
        ARB_GNT_MEM: begin
          ram_ce_next    = 1'b1;
          ram_addr_next  = mem_addr;
          ram_we_next    = mem_we;
          ram_wdata_next = mem_wdata;
        end
        ARB_GNT_IF: begin
          ram_ce_next    = 1'b1;
          ram_addr_next  = if_addr;
          ram_we_next    = WriteDisable;
          ram_wdata_next = DATA_W'(ZeroWord);
        end
        default: begin
          ram_ce_next = 1'b0;
          ram_we_next = WriteDisable;
        end
      endcase
    end
  end

  assign stallreq_if  = if_req  && !if_ack;
  assign stallreq_mem = mem_req && !mem_ack;

  assign ram_ce_o    = ram_ce_reg;
  assign ram_addr_o  = ram_addr_reg;
  assign ram_we_o    = ram_we_reg;
  assign ram_wdata_o = ram_wdata_reg;
  assign bus_err_o   = bus_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Inputs change on the falling edge;
// combinational outputs are checked 1 ns later, registered outputs are checked
// at the falling edge after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        ram_ce_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        ram_ready_i;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ack       (if_ack),
    .if_rdata     (if_rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem),
    .ram_ce_o     (ram_ce_o),
    .ram_addr_o   (ram_addr_o),
    .ram_we_o     (ram_we_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i),
    .ram_ready_i  (ram_ready_i),
    .bus_err_o    (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_addr = '0;
    mem_we = 4'b0; mem_wdata = '0; ram_rdata_i = '0; ram_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ce", 32'(ram_ce_o), 32'd0);
    chk("rst_addr", ram_addr_o, 32'h0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    chk("rst_wdata", ram_wdata_o, 32'h0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);

    // 1. Fetch only
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
    chk("t1_stall_rise", 32'(stallreq_if), 32'd1);
    chk("t1_ack_idle", 32'(if_ack), 32'd0);
    @(negedge clk); #1;
    chk("t1_ce", 32'(ram_ce_o), 32'd1);
    chk("t1_addr", ram_addr_o, 32'h40);
    chk("t1_we", 32'(ram_we_o), 32'd0);
    @(negedge clk); #1;
    chk("t1_stall_wait", 32'(stallreq_if), 32'd1);
    chk("t1_ack_wait", 32'(if_ack), 32'd0);
    @(negedge clk); ram_ready_i = 1'b1; ram_rdata_i = 32'h2402_0001; #1;
    chk("t1_ack", 32'(if_ack), 32'd1);
    chk("t1_rdata", if_rdata, 32'h2402_0001);
    chk("t1_stall_done", 32'(stallreq_if), 32'd0);
    @(negedge clk); if_req = 1'b0; ram_ready_i = 1'b0; #1;
    chk("t1_ce_idle", 32'(ram_ce_o), 32'd0);
    chk("t1_rdata_noack", if_rdata, 32'h0);

    // 2. Simultaneous requests: mem first, then fetch without a bubble
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h44;
    mem_req = 1'b1; mem_addr = 32'h100; mem_we = 4'b1111; mem_wdata = 32'hDEAD_BEEF; #1;
    chk("t2_stall_if", 32'(stallreq_if), 32'd1);
    chk("t2_stall_mem", 32'(stallreq_mem), 32'd1);
    @(negedge clk); #1;
    chk("t2_mem_addr", ram_addr_o, 32'h100);
    chk("t2_mem_we", 32'(ram_we_o), 32'hF);
    chk("t2_mem_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    ram_ready_i = 1'b1; ram_rdata_i = 32'h1111_1111; #1;
    chk("t2_mem_ack", 32'(mem_ack), 32'd1);
    chk("t2_store_rdata", mem_rdata, 32'h0);
    chk("t2_if_ack_none", 32'(if_ack), 32'd0);
    @(negedge clk); mem_req = 1'b0; ram_ready_i = 1'b0; #1;
    chk("t2_if_ce", 32'(ram_ce_o), 32'd1);
    chk("t2_if_addr", ram_addr_o, 32'h44);
    chk("t2_if_we", 32'(ram_we_o), 32'd0);
    chk("t2_if_wdata", ram_wdata_o, 32'h0);
    @(negedge clk); ram_ready_i = 1'b1; ram_rdata_i = 32'hCAFE_F00D; #1;
    chk("t2_if_ack", 32'(if_ack), 32'd1);
    chk("t2_if_rdata", if_rdata, 32'hCAFE_F00D);
    chk("t2_mem_ack_none", 32'(mem_ack), 32'd0);
    @(negedge clk); if_req = 1'b0; ram_ready_i = 1'b0; #1;
    chk("t2_ce_idle", 32'(ram_ce_o), 32'd0);

    // 3. Byte store then load
    @(negedge clk); mem_req = 1'b1; mem_addr = 32'h203; mem_we = 4'b0001; mem_wdata = 32'hAB;
    @(negedge clk); #1;
    chk("t3_st_we", 32'(ram_we_o), 32'h1);
    chk("t3_st_addr", ram_addr_o, 32'h203);
    chk("t3_st_wdata", ram_wdata_o, 32'hAB);
    ram_ready_i = 1'b1; ram_rdata_i = 32'h5566_7788; #1;
    chk("t3_st_ack", 32'(mem_ack), 32'd1);
    chk("t3_st_rdata", mem_rdata, 32'h0);
    @(negedge clk); ram_ready_i = 1'b0; mem_addr = 32'h200; mem_we = 4'b0000; #1;
    chk("t3_gap_ce", 32'(ram_ce_o), 32'd0);
    chk("t3_gap_ack", 32'(mem_ack), 32'd0);
    @(negedge clk); #1;
    chk("t3_ld_ce", 32'(ram_ce_o), 32'd1);
    chk("t3_ld_addr", ram_addr_o, 32'h200);
    chk("t3_ld_we", 32'(ram_we_o), 32'd0);
    ram_ready_i = 1'b1; ram_rdata_i = 32'h1234_5678; #1;
    chk("t3_ld_ack", 32'(mem_ack), 32'd1);
    chk("t3_ld_rdata", mem_rdata, 32'h1234_5678);
    @(negedge clk); mem_req = 1'b0; ram_ready_i = 1'b0;

    // 4. Timeout: ack on the 16th busy cycle, bus error the cycle after
    @(negedge clk); mem_req = 1'b1; mem_addr = 32'h300; mem_we = 4'b0; ram_rdata_i = 32'hFFFF_FFFF;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t4_noack_c%0d", i), 32'(mem_ack), 32'd0);
    end
    @(negedge clk); #1;
    chk("t4_to_ack", 32'(mem_ack), 32'd1);
    chk("t4_to_rdata", mem_rdata, 32'h0);
    chk("t4_err_early", 32'(bus_err_o), 32'd0);
    mem_req = 1'b0;
    @(negedge clk); #1;
    chk("t4_bus_err", 32'(bus_err_o), 32'd1);
    chk("t4_ce_idle", 32'(ram_ce_o), 32'd0);
    @(negedge clk); #1;
    chk("t4_err_pulse", 32'(bus_err_o), 32'd0);

    // 5. Reset in the middle of a grant
    @(negedge clk); mem_req = 1'b1; mem_addr = 32'h400; mem_we = 4'b1111; mem_wdata = 32'h1;
    @(negedge clk); #1;
    chk("t5_ce", 32'(ram_ce_o), 32'd1);
    rst = 1'b1; #1;
    chk("t5_no_ack", 32'(mem_ack), 32'd0);
    @(negedge clk); #1;
    chk("t5_rst_ce", 32'(ram_ce_o), 32'd0);
    chk("t5_rst_addr", ram_addr_o, 32'h0);
    chk("t5_rst_we", 32'(ram_we_o), 32'd0);
    chk("t5_rst_wdata", ram_wdata_o, 32'h0);
    rst = 1'b0; mem_addr = 32'h404; mem_we = 4'b0;
    @(negedge clk); #1;
    chk("t5_re_ce", 32'(ram_ce_o), 32'd1);
    chk("t5_re_addr", ram_addr_o, 32'h404);
    ram_ready_i = 1'b1; ram_rdata_i = 32'hA5A5_A5A5; #1;
    chk("t5_re_ack", 32'(mem_ack), 32'd1);
    chk("t5_re_rdata", mem_rdata, 32'hA5A5_A5A5);
    @(negedge clk); mem_req = 1'b0; ram_ready_i = 1'b0;

    // 6. Ready with nothing granted
    @(negedge clk); ram_ready_i = 1'b1; ram_rdata_i = 32'hFFFF_0000; #1;
    chk("t6_if_ack", 32'(if_ack), 32'd0);
    chk("t6_mem_ack", 32'(mem_ack), 32'd0);
    chk("t6_if_rdata", if_rdata, 32'h0);
    chk("t6_mem_rdata", mem_rdata, 32'h0);
    @(negedge clk); #1;
    chk("t6_ce", 32'(ram_ce_o), 32'd0);
    chk("t6_bus_err", 32'(bus_err_o), 32'd0);
    ram_ready_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
